// File: rtl/hyperbus_pkg.sv
// Shared HyperRAM register-space definitions: offsets, CFG0 layout, sequencer state and error codes.
// Pure types and constants; no latency or backpressure of its own.
package hyperbus_pkg;

   localparam logic [31:0] REG_ID0  = 32'h0000_0000;
   localparam logic [31:0] REG_ID1  = 32'h0000_0002;
   localparam logic [31:0] REG_CFG0 = 32'h0000_2000;
   localparam logic [31:0] REG_CFG1 = 32'h0000_2002;

   typedef struct packed {
      logic       deep_power_done;
      logic [2:0] drive_strength;
      logic [3:0] reserved;
      logic [3:0] initial_latency;
      logic       fixed_latency_enable;
      logic       hybrid_burst_enable;
      logic [1:0] burst_length;
   } cfg0_t;

   localparam logic [15:0] CFG0_DEFAULT = 16'h8F1F;

   typedef enum logic [3:0] {
      ST_IDLE, ST_WAIT_PWR, ST_RD_ID, ST_RD_ID_W, ST_WR_CFG,
      ST_WR_CFG_W, ST_RD_CFG, ST_RD_CFG_W, ST_DONE, ST_ERROR
   } cfg_state_e;

   typedef enum logic [1:0] {
      ERR_NONE     = 2'd0,
      ERR_TIMEOUT  = 2'd1,
      ERR_BAD_ID   = 2'd2,
      ERR_MISMATCH = 2'd3
   } err_code_e;

   // The device rejects CFG0 writes whose reserved nibble is not all ones.
   function automatic logic [15:0] cfg0_force_rsvd(input logic [15:0] value);
      cfg0_t c;
      c          = cfg0_t'(value);
      c.reserved = 4'hF;
      return c;
   endfunction

endpackage

// File: rtl/hyperbus_cfg_timer.sv
// Loadable up/down counter with a compare-equal terminal flag; term_o is combinational on the count.
// One cycle from load/enable to new count; no backpressure.
module hyperbus_cfg_timer #(
   parameter int unsigned      Width  = 11,
   parameter logic [Width-1:0] RstVal = '0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic [Width-1:0] load_val_i,
   input  logic             en_i,
   input  logic             up_i,
   input  logic [Width-1:0] term_val_i,
   output logic             term_o
);

   logic [Width-1:0] cnt_d, cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i) begin
         cnt_d = up_i ? cnt_q + Width'(1) : cnt_q - Width'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= RstVal;
      else         cnt_q <= cnt_d;
   end

   assign term_o = (cnt_q == term_val_i);

endmodule

// File: rtl/hyperbus_cfg_seq.sv
// Boot-time HyperRAM CFG0 sequencer: power-up wait, ID0 check, CFG0 write and readback with retries.
// Registered request outputs held until reg_gnt_i; no timeout applies while the controller stalls the grant.
module hyperbus_cfg_seq
   import hyperbus_pkg::*;
#(
   parameter int unsigned PowerUpCycles = 300,
   parameter int unsigned TimeoutCycles = 1024,
   parameter int unsigned MaxRetries    = 3,
   parameter logic [3:0]  ExpectedMfr   = 4'h1,
   parameter logic        AutoStart     = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        start_i,
   input  logic [15:0] cfg0_value_i,
   output logic        reg_req_o,
   input  logic        reg_gnt_i,
   output logic        reg_we_o,
   output logic [31:0] reg_addr_o,
   output logic [15:0] reg_wdata_o,
   input  logic        reg_rvalid_i,
   input  logic [15:0] reg_rdata_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        error_o,
   output logic [1:0]  err_code_o,
   output logic [15:0] id0_o
);

   localparam int unsigned TmrSpan = (PowerUpCycles > TimeoutCycles + 1) ? PowerUpCycles : TimeoutCycles + 1;
   localparam int unsigned TW      = (TmrSpan > 1) ? $clog2(TmrSpan) : 1;
   localparam int unsigned RW      = (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1;
   localparam cfg_state_e  RstState = AutoStart ? ST_WAIT_PWR : ST_IDLE;

   cfg_state_e  state_d, state_q;
   err_code_e   code_d, code_q;
   logic        req_d, req_q, we_d, we_q, busy_d, busy_q;
   logic        done_d, done_q, error_d, error_q, first_d, first_q;
   logic [31:0] addr_d, addr_q;
   logic [15:0] wdata_d, wdata_q, id0_d, id0_q, cfg_d, cfg_q;
   logic [RW-1:0] retry_d, retry_q;

   logic          tmr_load, tmr_en, tmr_up, tmr_term, can_retry;
   logic [TW-1:0] tmr_load_val, tmr_term_val;

   assign can_retry    = (retry_q < RW'(MaxRetries));
   assign tmr_term_val = (state_q == ST_WAIT_PWR) ? TW'(0) : TW'(TimeoutCycles);

   hyperbus_cfg_timer #(
      .Width  (TW),
      .RstVal (AutoStart ? TW'(PowerUpCycles - 1) : TW'(0))
   ) u_timer (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .load_i     (tmr_load),
      .load_val_i (tmr_load_val),
      .en_i       (tmr_en),
      .up_i       (tmr_up),
      .term_val_i (tmr_term_val),
      .term_o     (tmr_term)
   );

   always_comb begin
      state_d = state_q;  code_d = code_q;    req_d = req_q;      we_d = we_q;
      addr_d = addr_q;    wdata_d = wdata_q;  done_d = done_q;    error_d = error_q;
      id0_d = id0_q;      retry_d = retry_q;  first_d = 1'b0;
      // An auto-started sequence has no start pulse, so take the live value on the first cycle.
      cfg_d = first_q ? cfg0_force_rsvd(cfg0_value_i) : cfg_q;
      tmr_load = 1'b0;  tmr_load_val = '0;  tmr_en = 1'b0;  tmr_up = 1'b0;

      unique case (state_q)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (start_i) begin
               state_d = ST_WAIT_PWR;  done_d = 1'b0;  error_d = 1'b0;  code_d = ERR_NONE;
               retry_d = '0;  cfg_d = cfg0_force_rsvd(cfg0_value_i);
               tmr_load = 1'b1;  tmr_load_val = TW'(PowerUpCycles - 1);
            end
         end
         ST_WAIT_PWR: begin
            if (tmr_term) state_d = ST_RD_ID;
            else          tmr_en = 1'b1;
         end
         ST_RD_ID, ST_WR_CFG, ST_RD_CFG: begin
            if (reg_gnt_i) begin
               req_d = 1'b0;  tmr_load = 1'b1;
               state_d = (state_q == ST_RD_ID)  ? ST_RD_ID_W :
                         (state_q == ST_WR_CFG) ? ST_WR_CFG_W : ST_RD_CFG_W;
            end
         end
         ST_RD_ID_W, ST_WR_CFG_W, ST_RD_CFG_W: begin
            tmr_en = 1'b1;  tmr_up = 1'b1;
            if (reg_rvalid_i) begin
               if (state_q == ST_RD_ID_W) begin
                  id0_d = reg_rdata_i;
                  if (reg_rdata_i[3:0] != ExpectedMfr) begin
                     state_d = ST_ERROR;  code_d = ERR_BAD_ID;
                  end else begin
                     state_d = ST_WR_CFG;
                  end
               end else if (state_q == ST_WR_CFG_W) begin
                  state_d = ST_RD_CFG;
               end else if (reg_rdata_i == cfg_q) begin
                  state_d = ST_DONE;
               end else if (can_retry) begin
                  retry_d = retry_q + RW'(1);  state_d = ST_WR_CFG;
               end else begin
                  state_d = ST_ERROR;  code_d = ERR_MISMATCH;
               end
            end else if (tmr_term) begin
               if (can_retry) begin
                  retry_d = retry_q + RW'(1);
                  state_d = (state_q == ST_RD_ID_W)  ? ST_RD_ID :
                            (state_q == ST_WR_CFG_W) ? ST_WR_CFG : ST_RD_CFG;
               end else begin
                  state_d = ST_ERROR;  code_d = ERR_TIMEOUT;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Request-side outputs are set up on entry so they are stable from the first requesting cycle.
      if (state_d != state_q) begin
         unique case (state_d)
            ST_RD_ID:  begin req_d = 1'b1;  we_d = 1'b0;  addr_d = REG_ID0;  end
            ST_WR_CFG: begin req_d = 1'b1;  we_d = 1'b1;  addr_d = REG_CFG0;  wdata_d = cfg_q;  end
            ST_RD_CFG: begin req_d = 1'b1;  we_d = 1'b0;  addr_d = REG_CFG0;  end
            ST_DONE:   done_d  = 1'b1;
            ST_ERROR:  error_d = 1'b1;
            default:   ;
         endcase
      end
      busy_d = !(state_d inside {ST_IDLE, ST_DONE, ST_ERROR});
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= RstState;  code_q <= ERR_NONE;  req_q <= 1'b0;    we_q <= 1'b0;
         addr_q <= '0;         wdata_q <= '0;       done_q <= 1'b0;   error_q <= 1'b0;
         id0_q <= '0;          retry_q <= '0;       first_q <= 1'b1;  cfg_q <= '0;
         busy_q <= 1'b0;
      end else begin
         state_q <= state_d;   code_q <= code_d;    req_q <= req_d;   we_q <= we_d;
         addr_q <= addr_d;     wdata_q <= wdata_d;  done_q <= done_d; error_q <= error_d;
         id0_q <= id0_d;       retry_q <= retry_d;  first_q <= first_d; cfg_q <= cfg_d;
         busy_q <= busy_d;
      end
   end

   assign reg_req_o   = req_q;
   assign reg_we_o    = we_q;
   assign reg_addr_o  = addr_q;
   assign reg_wdata_o = wdata_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign error_o     = error_q;
   assign err_code_o  = code_q;
   assign id0_o       = id0_q;

endmodule

// File: tb/tb_hyperbus_cfg_seq.sv
// Directed bench for hyperbus_cfg_seq with a cycle-stepped HyperRAM register-port responder.
// Responses arrive two cycles after grant unless withheld; grant delay is programmable.
module tb_hyperbus_cfg_seq;
   import hyperbus_pkg::*;

   logic        clk_i = 1'b0, rst_ni = 1'b0, start_i = 1'b0;
   logic [15:0] cfg0_value_i = CFG0_DEFAULT;
   logic        reg_gnt_i = 1'b0, reg_rvalid_i = 1'b0;
   logic [15:0] reg_rdata_i = '0;
   logic        reg_req_o, reg_we_o, busy_o, done_o, error_o;
   logic [31:0] reg_addr_o;
   logic [15:0] reg_wdata_o, id0_o;
   logic [1:0]  err_code_o;

   always #5 clk_i = ~clk_i;

   hyperbus_cfg_seq #(
      .PowerUpCycles (300), .TimeoutCycles (1024), .MaxRetries (3),
      .ExpectedMfr (4'h1), .AutoStart (1'b1)
   ) dut (
      .clk_i (clk_i), .rst_ni (rst_ni), .start_i (start_i), .cfg0_value_i (cfg0_value_i),
      .reg_req_o (reg_req_o), .reg_gnt_i (reg_gnt_i), .reg_we_o (reg_we_o),
      .reg_addr_o (reg_addr_o), .reg_wdata_o (reg_wdata_o), .reg_rvalid_i (reg_rvalid_i),
      .reg_rdata_i (reg_rdata_i), .busy_o (busy_o), .done_o (done_o), .error_o (error_o),
      .err_code_o (err_code_o), .id0_o (id0_o)
   );

   int tests = 0, fails = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   logic [15:0] id_val = 16'h0C81, dev_cfg = '0, pend_data = '0;
   int          gnt_delay = 0, wr_withhold = 0, rd_bad = 0, pending = 0;
   bit          rst_mid = 1'b0, did_rst = 1'b0, in_req = 1'b0, busy_at1 = 1'b0;
   logic        log_we [64];
   logic [31:0] log_addr [64];
   logic [15:0] log_wdata [64];
   int          n_tx, first_req, first_hi, unstable, req_stuck, cyc, wait_cnt, n_wr;
   logic        s_we;
   logic [31:0] s_addr;
   logic [15:0] s_wdata;
   logic [70:0] all_out;

   task automatic chk_zero(input string tag);
      all_out = {reg_req_o, reg_we_o, reg_addr_o, reg_wdata_o, busy_o,
                 done_o, error_o, err_code_o, id0_o};
      chk(tag, all_out, 71'd0);
   endtask

   task automatic count_writes();
      n_wr = 0;
      for (int i = 0; i < n_tx && i < 64; i++) if (log_we[i]) n_wr++;
   endtask

   task automatic run_seq(input bit do_start);
      n_tx = 0; first_req = -1; first_hi = 0; unstable = 0; req_stuck = 0;
      cyc = 0; in_req = 1'b0; did_rst = 1'b0; wait_cnt = 0;
      if (do_start) start_i = 1'b1;
      while (cyc < 8000) begin
         @(posedge clk_i); #1;
         cyc++;
         start_i = 1'b0;
         if (cyc == 1) busy_at1 = busy_o;
         if (reg_gnt_i && reg_req_o) req_stuck++;
         reg_rvalid_i = 1'b0;
         if (pending > 0) begin
            pending--;
            if (pending == 0) begin reg_rvalid_i = 1'b1; reg_rdata_i = pend_data; end
         end
         if (rst_mid && reg_gnt_i && n_tx > 0 && log_we[n_tx-1]) begin
            reg_gnt_i = 1'b0; reg_rvalid_i = 1'b0; rst_ni = 1'b0;
            #1 chk_zero("mid_reset_outputs");
            pending = 3; pend_data = CFG0_DEFAULT; rst_mid = 1'b0; did_rst = 1'b1;
            @(negedge clk_i) rst_ni = 1'b1;
            break;
         end
         if (done_o || error_o) break;
         if (reg_req_o) begin
            if (first_req < 0) first_req = cyc;
            if (n_tx == 0) first_hi++;
            if (!in_req) begin
               in_req = 1'b1; wait_cnt = 0;
               s_we = reg_we_o; s_addr = reg_addr_o; s_wdata = reg_wdata_o;
            end else if (reg_we_o !== s_we || reg_addr_o !== s_addr || reg_wdata_o !== s_wdata) begin
               unstable++;
            end
            if (wait_cnt >= gnt_delay) begin
               reg_gnt_i = 1'b1; in_req = 1'b0;
               if (n_tx < 64) begin
                  log_we[n_tx] = reg_we_o; log_addr[n_tx] = reg_addr_o; log_wdata[n_tx] = reg_wdata_o;
               end
               n_tx++;
               if (reg_we_o) begin
                  dev_cfg = reg_wdata_o;
                  if (wr_withhold > 0) wr_withhold--;
                  else begin pending = 2; pend_data = 16'h0000; end
               end else if (reg_addr_o == REG_ID0) begin
                  pending = 2; pend_data = id_val;
               end else begin
                  pending = 2;
                  if (rd_bad > 0) begin pend_data = 16'h8F1E; rd_bad--; end
                  else pend_data = dev_cfg;
               end
            end else begin
               reg_gnt_i = 1'b0; wait_cnt++;
            end
         end else begin
            reg_gnt_i = 1'b0; in_req = 1'b0;
         end
      end
      reg_gnt_i = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge clk_i);
      #1 chk_zero("reset_outputs");
      @(negedge clk_i) rst_ni = 1'b1;

      // Nominal auto-start
      run_seq(1'b0);
      chk("nom_busy_after_reset", busy_at1, 1'b1);
      chk("nom_first_req_cycle", first_req, 300);
      chk("nom_n_tx", n_tx, 3);
      chk("nom_tx0", {log_we[0], log_addr[0]}, {1'b0, 32'h0000_0000});
      chk("nom_tx1", {log_we[1], log_addr[1], log_wdata[1]}, {1'b1, 32'h0000_2000, 16'h8F1F});
      chk("nom_tx2", {log_we[2], log_addr[2]}, {1'b0, 32'h0000_2000});
      chk("nom_done", {done_o, error_o, err_code_o, busy_o}, 5'b10_000);
      chk("nom_id0", id0_o, 16'h0C81);
      chk("nom_handshake", req_stuck, 0);

      // Restart from DONE with a value whose reserved nibble must be forced
      cfg0_value_i = 16'h801E;
      run_seq(1'b1);
      cfg0_value_i = CFG0_DEFAULT;
      chk("restart_first_req_cycle", first_req, 301);
      chk("restart_wdata", log_wdata[1], 16'h8F1E);
      chk("restart_done", done_o, 1'b1);

      // Bad manufacturer ID
      id_val = 16'h0C82;
      run_seq(1'b1);
      id_val = 16'h0C81;
      chk("badid_err", {error_o, done_o, err_code_o}, 4'b10_10);
      chk("badid_no_write", n_tx, 1);
      chk("badid_id0", id0_o, 16'h0C82);

      // One withheld write response
      wr_withhold = 1;
      run_seq(1'b1);
      chk("to1_n_tx", n_tx, 4);
      chk("to1_reissue", {log_we[2], log_addr[2]}, {1'b1, 32'h0000_2000});
      chk("to1_done", {done_o, error_o}, 2'b10);

      // Every write attempt withheld
      wr_withhold = 4;
      run_seq(1'b1);
      count_writes();
      chk("to4_err", {error_o, done_o, err_code_o}, 4'b10_01);
      chk("to4_writes", n_wr, 4);
      repeat (20) @(posedge clk_i);
      #1 chk("to4_hold", {error_o, reg_req_o, busy_o}, 3'b100);

      // Readback mismatch on every attempt
      rd_bad = 4;
      run_seq(1'b1);
      count_writes();
      chk("mm4_err", {error_o, err_code_o}, 3'b1_11);
      chk("mm4_writes", n_wr, 4);
      chk("mm4_n_tx", n_tx, 9);

      // Two mismatches then success; retries must have been cleared by start
      rd_bad = 2;
      run_seq(1'b1);
      chk("mm2_done", {done_o, error_o, err_code_o}, 4'b10_00);
      chk("mm2_n_tx", n_tx, 7);

      // Slow grant
      gnt_delay = 50;
      run_seq(1'b1);
      gnt_delay = 0;
      chk("gnt_req_held", first_hi, 51);
      chk("gnt_stable", unstable, 0);
      chk("gnt_no_retry", n_tx, 3);
      chk("gnt_done", done_o, 1'b1);

      // Reset during the CFG0 write wait, with a late response arriving afterwards
      rst_mid = 1'b1;
      run_seq(1'b1);
      chk("rst_hit_wr_wait", did_rst, 1'b1);
      run_seq(1'b0);
      chk("rst_first_req_cycle", first_req, 300);
      chk("rst_n_tx", n_tx, 3);
      chk("rst_order", {log_we[0], log_we[1], log_we[2]}, 3'b010);
      chk("rst_done", {done_o, error_o, id0_o}, {2'b10, 16'h0C81});

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
